// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache has priority with a starvation guard for icache.
// Optional ARB_STATS_EN macro adds saturating per-port completion counters on icnt/dcnt.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err,
  output logic [31:0] icnt,
  output logic [31:0] dcnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  arb_state_t    state, next_state;
  logic [SW-1:0] starve_cnt;
  logic          dreq;
  logic          starved;
  logic          i_done;
  logic          d_done;

  assign dreq    = dREN | dWEN;
  assign starved = (starve_cnt >= SW'(STARVE_LIMIT));
  // A completion needs the owner still requesting; a dropped request ends the grant silently.
  assign i_done  = (state == IGRANT) && iREN && (ramstate == RAM_ACCESS);
  assign d_done  = (state == DGRANT) && dreq && (ramstate == RAM_ACCESS);

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dreq && iREN) next_state = starved ? IGRANT : DGRANT;
        else if (dreq)    next_state = DGRANT;
        else if (iREN)    next_state = IGRANT;
      end
      DGRANT:  if (!dreq || ramstate == RAM_ACCESS) next_state = IDLE;
      IGRANT:  if (!iREN || ramstate == RAM_ACCESS) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = ~i_done;
    dwait    = ~d_done;
    case (state)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
  end

  // Counts icache cycles spent waiting outside IGRANT; cleared on grant or when icache goes quiet.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= '0;
    else if (!iREN || (next_state == IGRANT && state != IGRANT))
      starve_cnt <= '0;
    else if (state != IGRANT && !starved)
      starve_cnt <= starve_cnt + SW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      ram_err <= 1'b0;
    else if (state != IDLE && ramstate == RAM_ERROR)
      ram_err <= 1'b1;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt <= 32'd0;
      dcnt <= 32'd0;
    end else begin
      if (i_done && icnt != 32'hFFFF_FFFF) icnt <= icnt + 32'd1;
      if (d_done && dcnt != 32'hFFFF_FFFF) dcnt <= dcnt + 32'd1;
    end
  end
`else
  assign icnt = 32'd0;
  assign dcnt = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: driver pushes expected transfers, a negedge monitor checks completions.
module tb_cache_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload;
  logic        iwait, dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        ram_err;
  logic [31:0] icnt, dcnt;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  // Expected entry: {is_dcache, is_write, addr, data}
  logic [65:0] exp_q[$];
  logic [65:0] m_e;
  int checks = 0;
  int passes = 0;
  int exp_i  = 0;
  int exp_d  = 0;

  cache_mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
    .icnt(icnt), .dcnt(dcnt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic push_exp(input logic is_d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_q.push_back({is_d, wen, addr, data});
    if (is_d) exp_d++;
    else      exp_i++;
  endtask

  // Wait for the monitor to consume all expectations, then drop every request in the next IDLE cycle.
  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check32("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait)) begin
      if (exp_q.size() == 0) begin
        check32("unexpected_done", {30'd0, iwait, dwait}, 32'd3);
      end else begin
        m_e = exp_q.pop_front();
        check32("owner_waits", {30'd0, iwait, dwait}, m_e[65] ? 32'd2 : 32'd1);
        check1("done_ramWEN", ramWEN, m_e[64]);
        check1("done_ramREN", ramREN, ~m_e[64]);
        check32("done_ramaddr", ramaddr, m_e[63:32]);
        check32("done_data", m_e[64] ? ramstore : (m_e[65] ? dload : iload), m_e[31:0]);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    repeat (2) @(negedge CLK);
    check1("rst_iwait", iwait, 1'b1);
    check1("rst_dwait", dwait, 1'b1);
    check1("rst_ramREN", ramREN, 1'b0);
    check1("rst_ramWEN", ramWEN, 1'b0);
    check32("rst_ramaddr", ramaddr, 32'd0);
    check32("rst_ramstore", ramstore, 32'd0);
    check1("rst_ram_err", ram_err, 1'b0);
    check32("rst_icnt", icnt, 32'd0);
    check32("rst_dcnt", dcnt, 32'd0);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset in the middle of an icache grant, then re-grant after release
    ramstate = BUSY; iREN = 1'b1; iaddr = 32'h500; ramload = 32'h99;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check1("mid_grant_ramREN", ramREN, 1'b1);
    #1 nRST = 1'b0;
    exp_i = 0;
    exp_d = 0;
    #1;
    check1("async_rst_ramREN", ramREN, 1'b0);
    check1("async_rst_iwait", iwait, 1'b1);
    check32("async_rst_ramaddr", ramaddr, 32'd0);
    #1 nRST = 1'b1;
    ramstate = ACCESS;
    push_exp(1'b0, 1'b0, 32'h500, 32'h99);
    drain(2);

    // Dcache read with immediate ACCESS: 2-cycle transfer
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF; dREN = 1'b1; daddr = 32'h40;
    push_exp(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    @(negedge CLK);
    check1("lat_idle_dwait", dwait, 1'b1);
    check1("lat_idle_ramREN", ramREN, 1'b0);
    drain(2);

    // Read and write together: write wins
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234_5678;
    push_exp(1'b1, 1'b1, 32'h80, 32'h1234_5678);
    drain(4);

    // Plain icache read
    iREN = 1'b1; iaddr = 32'h100; ramload = 32'hCAFE_F00D;
    push_exp(1'b0, 1'b0, 32'h100, 32'hCAFE_F00D);
    drain(4);

    // Both requesting continuously: 4 dcache transfers, then 1 icache, repeating
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300; ramload = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) push_exp(1'b1, 1'b0, 32'h300, 32'h5555_AAAA);
      push_exp(1'b0, 1'b0, 32'h200, 32'h5555_AAAA);
    end
    drain(30);

    // BUSY x3, ERROR x1, then ACCESS while granted to dcache
    dREN = 1'b1; daddr = 32'h44; ramload = 32'h77; ramstate = BUSY;
    push_exp(1'b1, 1'b0, 32'h44, 32'h77);
    @(negedge CLK);
    check1("busy_idle_dwait", dwait, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      ramstate = (k == 3) ? ERROR : BUSY;
      @(negedge CLK);
      check1("busy_dwait", dwait, 1'b1);
      check1("busy_ramREN", ramREN, 1'b1);
    end
    @(posedge CLK);
    #1;
    ramstate = ACCESS;
    check1("err_set", ram_err, 1'b1);
    drain(2);
    @(negedge CLK);
    check1("err_sticky", ram_err, 1'b1);

    // Owner drops its request while granted: no completion pulse
    @(posedge CLK);
    #1;
    ramstate = BUSY; dREN = 1'b1; daddr = 32'h48;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check1("drop_granted_ramREN", ramREN, 1'b1);
    #1;
    dREN = 1'b0;
    ramstate = ACCESS;
    #1;
    check1("drop_no_pulse", dwait, 1'b1);
    check1("drop_ramREN", ramREN, 1'b0);
    @(negedge CLK);
    check1("drop_idle_dwait", dwait, 1'b1);
    check32("drop_idle_ramaddr", ramaddr, 32'd0);

    @(negedge CLK);
`ifdef ARB_STATS_EN
    check32("stats_icnt", icnt, 32'(exp_i));
    check32("stats_dcnt", dcnt, 32'(exp_d));
`else
    check32("stats_icnt", icnt, 32'd0);
    check32("stats_dcnt", dcnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
